// File: rtl/writeback_queue.sv
// Writeback queue: buffers ld/ex register writes, drains one per cycle.
// Optional same-cycle rf bypass when empty: define WBQ_BYPASS_EN.
module writeback_queue #(
  parameter int COUNT     = 32,
  parameter int BUS_WIDTH = 32,
  parameter int DEPTH     = 4,
  localparam int ADDR_WIDTH = $clog2(COUNT),
  localparam int CNT_WIDTH  = $clog2(DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ld_valid,
  output logic                  ld_ready,
  input  logic [ADDR_WIDTH-1:0] ld_addr,
  input  logic [BUS_WIDTH-1:0]  ld_data,
  input  logic                  ex_valid,
  output logic                  ex_ready,
  input  logic [ADDR_WIDTH-1:0] ex_addr,
  input  logic [BUS_WIDTH-1:0]  ex_data,
  output logic                  rf_wr_en,
  output logic [ADDR_WIDTH-1:0] rf_write_addr,
  output logic [BUS_WIDTH-1:0]  rf_data_in,
  output logic [COUNT-1:0]      pending,
  output logic [CNT_WIDTH-1:0]  count,
  output logic                  full,
  output logic                  empty
);

  localparam int PW = $clog2(DEPTH);

  logic [ADDR_WIDTH-1:0] addr_q [DEPTH];
  logic [BUS_WIDTH-1:0]  data_q [DEPTH];
  logic [DEPTH-1:0]      vld_q;
  logic [PW-1:0]         head_q, head_d;
  logic [PW-1:0]         tail_q, tail_d;
  logic [PW-1:0]         ex_slot;
  logic [CNT_WIDTH-1:0]  count_q, count_d;
  logic [CNT_WIDTH-1:0]  free;
  logic                  q_empty;
  logic                  ld_st, ex_st;
  logic                  byp_ld, byp_ex;
  logic                  ld_en, ex_en;
  logic                  deq;
  logic [COUNT-1:0]      pend;

  assign free    = CNT_WIDTH'(DEPTH) - count_q;
  assign q_empty = (count_q == '0);

  // Readiness uses registered occupancy; the concurrent pop is not credited.
  assign ld_ready = !rst && (free != '0);
  assign ex_ready = !rst && ((free >= CNT_WIDTH'(2)) ||
                             ((free != '0) && !ld_valid));

  // Writes to r0 finish the handshake but are dropped.
  assign ld_st = ld_valid && ld_ready && (ld_addr != '0);
  assign ex_st = ex_valid && ex_ready && (ex_addr != '0);

`ifdef WBQ_BYPASS_EN
  assign byp_ld = q_empty && !rst && ld_st;
  assign byp_ex = q_empty && !rst && ex_st && !ld_st;
`else
  assign byp_ld = 1'b0;
  assign byp_ex = 1'b0;
`endif

  assign ld_en   = ld_st && !byp_ld;
  assign ex_en   = ex_st && !byp_ex;
  assign deq     = !rst && !q_empty;
  assign ex_slot = tail_q + PW'(ld_en);

  // Next-state pointers and occupancy.
  always_comb begin
    head_d  = head_q + PW'(deq);
    tail_d  = tail_q + PW'(ld_en) + PW'(ex_en);
    count_d = count_q + CNT_WIDTH'(ld_en)
            + CNT_WIDTH'(ex_en) - CNT_WIDTH'(deq);
  end

  // Queue state: reset flushes every entry, else pop head and push ld then ex.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      vld_q   <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      if (deq) vld_q[head_q] <= 1'b0;
      if (ld_en) begin
        vld_q[tail_q]  <= 1'b1;
        addr_q[tail_q] <= ld_addr;
        data_q[tail_q] <= ld_data;
      end
      if (ex_en) begin
        vld_q[ex_slot]  <= 1'b1;
        addr_q[ex_slot] <= ex_addr;
        data_q[ex_slot] <= ex_data;
      end
    end
  end

  // Per-register pending vector over live entries.
  always_comb begin
    pend = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld_q[i]) pend[addr_q[i]] = 1'b1;
    end
    pend[0] = 1'b0;
    pending = rst ? '0 : pend;
  end

  // Register file port: bypassed request, else queue head, else idle zeros.
  always_comb begin
    rf_wr_en      = 1'b0;
    rf_write_addr = '0;
    rf_data_in    = '0;
    if (byp_ld) begin
      rf_wr_en      = 1'b1;
      rf_write_addr = ld_addr;
      rf_data_in    = ld_data;
    end else if (byp_ex) begin
      rf_wr_en      = 1'b1;
      rf_write_addr = ex_addr;
      rf_data_in    = ex_data;
    end else if (deq) begin
      rf_wr_en      = 1'b1;
      rf_write_addr = addr_q[head_q];
      rf_data_in    = data_q[head_q];
    end
  end

  assign count = rst ? '0 : count_q;
  assign empty = rst || q_empty;
  assign full  = !rst && (count_q == CNT_WIDTH'(DEPTH));

endmodule

// File: tb/tb_writeback_queue.sv
// Bench for writeback_queue: occupancy model plus rf-write scoreboard.
// Directed scenarios followed by a random phase.
module tb_writeback_queue;

  localparam int COUNT = 32;
  localparam int BW    = 32;
  localparam int DEPTH = 4;
  localparam int AW    = 5;
  localparam int CW    = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          ld_valid, ex_valid;
  logic          ld_ready, ex_ready;
  logic [AW-1:0] ld_addr, ex_addr;
  logic [BW-1:0] ld_data, ex_data;
  logic          rf_wr_en;
  logic [AW-1:0] rf_write_addr;
  logic [BW-1:0] rf_data_in;
  logic [COUNT-1:0] pending;
  logic [CW-1:0] count;
  logic          full, empty;

  always #5 clk = ~clk;

  writeback_queue dut (
    .clk(clk), .rst(rst),
    .ld_valid(ld_valid), .ld_ready(ld_ready),
    .ld_addr(ld_addr), .ld_data(ld_data),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_addr(ex_addr), .ex_data(ex_data),
    .rf_wr_en(rf_wr_en), .rf_write_addr(rf_write_addr),
    .rf_data_in(rf_data_in), .pending(pending),
    .count(count), .full(full), .empty(empty)
  );

  typedef struct packed {
    logic [AW-1:0] a;
    logic [BW-1:0] d;
  } ent_t;

  ent_t sb[$];
  int   nvec = 0;
  int   nbad = 0;
  logic lacc, eacc;

  task automatic chk(string tag, logic [63:0] got, logic [63:0] exp);
    nvec++;
    if (got !== exp) begin
      nbad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // One clock: check outputs mid-cycle, then advance the model past the edge.
  task automatic step();
    int fr;
    logic er_ld, er_ex, wr, pl, pe, bl, be;
    logic [AW-1:0] wa;
    logic [BW-1:0] wd;
    logic [COUNT-1:0] pn;
    @(negedge clk);
    fr = DEPTH - sb.size();
    er_ld = !rst && fr >= 1;
    er_ex = !rst && (fr >= 2 || (fr >= 1 && !ld_valid));
    lacc = ld_valid && er_ld;
    eacc = ex_valid && er_ex;
    pl = lacc && ld_addr != 0;
    pe = eacc && ex_addr != 0;
    bl = 1'b0;
    be = 1'b0;
`ifdef WBQ_BYPASS_EN
    bl = sb.size() == 0 && !rst && pl;
    be = sb.size() == 0 && !rst && pe && !pl;
`endif
    pn = '0;
    foreach (sb[i]) pn[sb[i].a] = 1'b1;
    if (rst) pn = '0;
    wr = 1'b0;
    wa = '0;
    wd = '0;
    if (bl) begin
      wr = 1'b1; wa = ld_addr; wd = ld_data;
    end else if (be) begin
      wr = 1'b1; wa = ex_addr; wd = ex_data;
    end else if (!rst && sb.size() > 0) begin
      wr = 1'b1; wa = sb[0].a; wd = sb[0].d;
    end
    chk("ld_ready", ld_ready, er_ld);
    chk("ex_ready", ex_ready, er_ex);
    chk("count", count, rst ? 0 : sb.size());
    chk("empty", empty, rst || sb.size() == 0);
    chk("full", full, !rst && sb.size() == DEPTH);
    chk("pending", pending, pn);
    chk("rf_wr_en", rf_wr_en, wr);
    chk("rf_addr", rf_write_addr, wa);
    chk("rf_data", rf_data_in, wd);
    @(posedge clk);
    if (rst) begin
      sb.delete();
    end else begin
      if (sb.size() > 0) void'(sb.pop_front());
      if (pl && !bl) sb.push_back('{a: ld_addr, d: ld_data});
      if (pe && !be) sb.push_back('{a: ex_addr, d: ex_data});
    end
    #1;
  endtask

  task automatic idle();
    ld_valid = 1'b0;
    ex_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    ld_addr = '0; ld_data = '0;
    ex_addr = '0; ex_data = '0;
    step();
    step();
    rst = 1'b0;
    step();

    // single ex write
    ex_valid = 1'b1; ex_addr = 5; ex_data = 32'hDEADBEEF;
    step();
    idle();
    step();
    step();

    // both ports streaming, hold until accepted
    ld_valid = 1'b1; ld_addr = 1; ld_data = 32'h100;
    ex_valid = 1'b1; ex_addr = 2; ex_data = 32'h200;
    for (int k = 0; k < 8; k++) begin
      step();
      if (lacc) begin
        ld_addr = ld_addr + 2; ld_data = ld_data + 1;
      end
      if (eacc) begin
        ex_addr = ex_addr + 2; ex_data = ex_data + 1;
      end
    end
    idle();
    repeat (5) step();

    // r0 writes are dropped
    ld_valid = 1'b1; ld_addr = 0; ld_data = 32'h11;
    ex_valid = 1'b1; ex_addr = 0; ex_data = 32'h22;
    step();
    idle();
    step();

    // flush by reset mid-operation
    ld_valid = 1'b1; ld_addr = 8;  ld_data = 32'hA8;
    ex_valid = 1'b1; ex_addr = 9;  ex_data = 32'hA9;
    step();
    ld_addr = 10; ld_data = 32'hAA;
    ex_addr = 11; ex_data = 32'hAB;
    step();
    idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
    repeat (3) step();

    // same register from both ports
    ld_valid = 1'b1; ld_addr = 7; ld_data = 32'h1;
    ex_valid = 1'b1; ex_addr = 7; ex_data = 32'h2;
    step();
    idle();
    repeat (3) step();

    // random traffic, requests held until accepted
    for (int k = 0; k < 300; k++) begin
      if (!ld_valid || lacc) begin
        ld_valid = ($urandom_range(0, 3) != 0);
        ld_addr  = AW'($urandom_range(0, 31));
        ld_data  = $urandom;
      end
      if (!ex_valid || eacc) begin
        ex_valid = ($urandom_range(0, 3) != 0);
        ex_addr  = AW'($urandom_range(0, 31));
        ex_data  = $urandom;
      end
      rst = ($urandom_range(0, 99) == 0);
      step();
    end
    rst = 1'b0;
    idle();
    repeat (6) step();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end

endmodule
